// File: rtl/mig_arb_pkg.sv
// mig_arb_pkg: shared types and MIG command encodings for the command arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mig_arb_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_BURST = 2'd2,
        DONE     = 2'd3
    } arb_state_e;

    // MIG UI app_cmd encodings.
    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;
    // Value driven on app_cmd when no burst is active.
    localparam logic [2:0] CMD_IDLE  = 3'b000;

endpackage

// File: rtl/mig_burst_counter.sv
// mig_burst_counter: beat counter that latches a burst length on load and counts up to it.
// Latency: count and reached update one cycle after load/inc.
// Backpressure: inc is ignored once count has reached the latched length.
// Ports: clk/rst (async, active-high); load + load_len clear the count and capture the length;
//        inc advances the count; count is the current value; reached is high when count == length.
module mig_burst_counter #(
    parameter int LW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [LW-1:0] load_len,
    input  logic          inc,
    output logic [LW-1:0] count,
    output logic          reached
);

    logic [LW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] len_q, len_d;

    assign count   = cnt_q;
    assign reached = (cnt_q >= len_q);

    always_comb begin
        cnt_d = cnt_q;
        len_d = len_q;
        if (load) begin
            cnt_d = '0;
            len_d = load_len;
        end else if (inc && !reached) begin
            cnt_d = cnt_q + LW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            len_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            len_q <= len_d;
        end
    end

endmodule

// File: rtl/mig_cmd_arbiter.sv
// mig_cmd_arbiter: round-robin arbiter turning write/read burst requests into MIG UI app_* traffic.
// Latency: grant one cycle after a request is sampled in IDLE; done one cycle after the last beat, then one DONE cycle.
// Backpressure: commands held while app_rdy=0; write data held via wr_data_ready while app_wdf_rdy=0; no grants while init_calib=0.
// Ports: aclk/reset (async, active-high); wr_*/rd_* request side (req/addr/len in, grant/done pulses out);
//        wr_data/wr_data_valid/wr_data_ready write beat stream; app_* and app_wdf_* to the MIG user interface.
module mig_cmd_arbiter
    import mig_arb_pkg::*;
#(
    parameter int MIG_Addr_Port_Size = 28,
    parameter int MIG_Data_Port_Size = 128,
    parameter int Max_Burst_Len      = 16,
    parameter int Addr_Step          = 8,
    localparam int AW = MIG_Addr_Port_Size,
    localparam int DW = MIG_Data_Port_Size,
    localparam int LW = $clog2(Max_Burst_Len + 1)
) (
    input  logic            aclk,
    input  logic            reset,
    input  logic            init_calib,
    input  logic            wr_req,
    input  logic [AW-1:0]   wr_addr,
    input  logic [LW-1:0]   wr_len,
    output logic            wr_grant,
    output logic            wr_done,
    input  logic [DW-1:0]   wr_data,
    input  logic            wr_data_valid,
    output logic            wr_data_ready,
    input  logic            rd_req,
    input  logic [AW-1:0]   rd_addr,
    input  logic [LW-1:0]   rd_len,
    output logic            rd_grant,
    output logic            rd_done,
    output logic [AW-1:0]   app_addr,
    output logic [2:0]      app_cmd,
    output logic            app_en,
    input  logic            app_rdy,
    output logic [DW-1:0]   app_wdf_data,
    output logic            app_wdf_wren,
    output logic            app_wdf_end,
    output logic [DW/8-1:0] app_wdf_mask,
    input  logic            app_wdf_rdy
);

    localparam logic [LW-1:0] MAX_LEN   = LW'(Max_Burst_Len);
    localparam logic [AW-1:0] ADDR_STEP = AW'(Addr_Step);

    arb_state_e    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          is_wr_q, is_wr_d;
    logic          prefer_rd_q, prefer_rd_d;
    logic          wr_grant_q, wr_grant_d;
    logic          rd_grant_q, rd_grant_d;
    logic          wr_done_q, wr_done_d;
    logic          rd_done_q, rd_done_d;

    logic [LW-1:0] wr_len_c, rd_len_c;
    logic          pick_rd;
    logic          cnt_load;
    logic [LW-1:0] cnt_len;
    logic [LW-1:0] cmd_cnt, dat_cnt;
    logic          cmd_reached, dat_reached;
    logic          cmd_inc, dat_inc;
    logic          in_wr, in_rd, in_burst;

    // Oversized lengths are clamped rather than rejected.
    assign wr_len_c = (wr_len > MAX_LEN) ? MAX_LEN : wr_len;
    assign rd_len_c = (rd_len > MAX_LEN) ? MAX_LEN : rd_len;

    // Read wins only if write is absent or write was the port served last.
    assign pick_rd = rd_req && (!wr_req || prefer_rd_q);

    assign in_wr    = (state_q == WR_BURST);
    assign in_rd    = (state_q == RD_BURST);
    assign in_burst = in_wr || in_rd;

    // Command path: one command per app_en & app_rdy, address advances per accepted command.
    assign app_en   = in_burst && !cmd_reached;
    assign cmd_inc  = app_en && app_rdy;
    assign app_addr = addr_q + AW'(cmd_cnt) * ADDR_STEP;
    assign app_cmd  = in_wr ? CMD_WRITE : (in_rd ? CMD_READ : CMD_IDLE);

    // Write data path runs independently of the command path, so data may lead or lag.
    assign wr_data_ready = in_wr && app_wdf_rdy && !dat_reached;
    assign app_wdf_wren  = in_wr && wr_data_valid && !dat_reached;
    assign app_wdf_end   = app_wdf_wren;
    assign dat_inc       = app_wdf_wren && app_wdf_rdy;
    assign app_wdf_data  = in_wr ? wr_data : '0;
    assign app_wdf_mask  = '0;

    assign wr_grant = wr_grant_q;
    assign rd_grant = rd_grant_q;
    assign wr_done  = wr_done_q;
    assign rd_done  = rd_done_q;

    mig_burst_counter #(.LW(LW)) u_cmd_cnt (
        .clk      (aclk),
        .rst      (reset),
        .load     (cnt_load),
        .load_len (cnt_len),
        .inc      (cmd_inc),
        .count    (cmd_cnt),
        .reached  (cmd_reached)
    );

    mig_burst_counter #(.LW(LW)) u_dat_cnt (
        .clk      (aclk),
        .rst      (reset),
        .load     (cnt_load),
        .load_len (cnt_len),
        .inc      (dat_inc),
        .count    (dat_cnt),
        .reached  (dat_reached)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        is_wr_d     = is_wr_q;
        prefer_rd_d = prefer_rd_q;
        wr_grant_d  = 1'b0;
        rd_grant_d  = 1'b0;
        wr_done_d   = 1'b0;
        rd_done_d   = 1'b0;
        cnt_load    = 1'b0;
        cnt_len     = '0;
        case (state_q)
            IDLE: begin
                if (init_calib && (wr_req || rd_req)) begin
                    cnt_load   = 1'b1;
                    cnt_len    = pick_rd ? rd_len_c : wr_len_c;
                    addr_d     = pick_rd ? rd_addr : wr_addr;
                    is_wr_d    = !pick_rd;
                    wr_grant_d = !pick_rd;
                    rd_grant_d = pick_rd;
                    // Zero-length bursts skip the burst state: grant and done share the DONE cycle.
                    if (cnt_len == '0) begin
                        state_d   = DONE;
                        wr_done_d = !pick_rd;
                        rd_done_d = pick_rd;
                    end else begin
                        state_d = pick_rd ? RD_BURST : WR_BURST;
                    end
                end
            end
            WR_BURST: begin
                // All commands issued and data count caught up with them means both are at len.
                if (cmd_reached && (dat_cnt == cmd_cnt)) begin
                    state_d   = DONE;
                    wr_done_d = 1'b1;
                end
            end
            RD_BURST: begin
                if (cmd_reached) begin
                    state_d   = DONE;
                    rd_done_d = 1'b1;
                end
            end
            DONE: begin
                state_d     = IDLE;
                prefer_rd_d = is_wr_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            is_wr_q     <= 1'b0;
            prefer_rd_q <= 1'b0;
            wr_grant_q  <= 1'b0;
            rd_grant_q  <= 1'b0;
            wr_done_q   <= 1'b0;
            rd_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            is_wr_q     <= is_wr_d;
            prefer_rd_q <= prefer_rd_d;
            wr_grant_q  <= wr_grant_d;
            rd_grant_q  <= rd_grant_d;
            wr_done_q   <= wr_done_d;
            rd_done_q   <= rd_done_d;
        end
    end

endmodule

// File: tb/tb_mig_cmd_arbiter.sv
// tb_mig_cmd_arbiter: directed bench with a scoreboard of expected grants, commands, data beats and dones.
// Latency: n/a.
// Backpressure: app_rdy / app_wdf_rdy driven by the directed steps.
module tb_mig_cmd_arbiter;

    logic         aclk;
    logic         reset;
    logic         init_calib;
    logic         wr_req;
    logic [27:0]  wr_addr;
    logic [4:0]   wr_len;
    logic         wr_grant;
    logic         wr_done;
    logic [127:0] wr_data;
    logic         wr_data_valid;
    logic         wr_data_ready;
    logic         rd_req;
    logic [27:0]  rd_addr;
    logic [4:0]   rd_len;
    logic         rd_grant;
    logic         rd_done;
    logic [27:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en;
    logic         app_rdy;
    logic [127:0] app_wdf_data;
    logic         app_wdf_wren;
    logic         app_wdf_end;
    logic [15:0]  app_wdf_mask;
    logic         app_wdf_rdy;

    mig_cmd_arbiter dut (
        .aclk          (aclk),
        .reset         (reset),
        .init_calib    (init_calib),
        .wr_req        (wr_req),
        .wr_addr       (wr_addr),
        .wr_len        (wr_len),
        .wr_grant      (wr_grant),
        .wr_done       (wr_done),
        .wr_data       (wr_data),
        .wr_data_valid (wr_data_valid),
        .wr_data_ready (wr_data_ready),
        .rd_req        (rd_req),
        .rd_addr       (rd_addr),
        .rd_len        (rd_len),
        .rd_grant      (rd_grant),
        .rd_done       (rd_done),
        .app_addr      (app_addr),
        .app_cmd       (app_cmd),
        .app_en        (app_en),
        .app_rdy       (app_rdy),
        .app_wdf_data  (app_wdf_data),
        .app_wdf_wren  (app_wdf_wren),
        .app_wdf_end   (app_wdf_end),
        .app_wdf_mask  (app_wdf_mask),
        .app_wdf_rdy   (app_wdf_rdy)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct packed {
        logic        rd;
        logic [31:0] cmd_tot;
        logic [31:0] dat_tot;
    } done_t;

    logic [1:0]   exp_gnt[$];
    logic [30:0]  exp_cmd[$];
    logic [127:0] exp_dat[$];
    done_t        exp_done[$];

    int          checks = 0;
    int          errors = 0;
    int unsigned cmd_seen = 0, dat_seen = 0, cmd_pushed = 0, dat_pushed = 0;
    int unsigned mark_cmd, mark_dat;
    bit          toggle_rdy = 1'b0;
    done_t       mon_d;
    logic [1:0]  mon_g;

    task automatic chk(input string tag, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
        end
    endtask

    function automatic logic [191:0] outs();
        return {9'd0, wr_grant, wr_done, wr_data_ready, rd_grant, rd_done, app_addr, app_cmd,
                app_en, app_wdf_data, app_wdf_wren, app_wdf_end, app_wdf_mask};
    endfunction

    // Expected traffic for one burst, derived from the request parameters alone.
    task automatic push_burst(input bit rd, input logic [27:0] addr, input int len);
        int    n;
        done_t d;
        n = (len > 16) ? 16 : len;
        exp_gnt.push_back(rd ? 2'b10 : 2'b01);
        for (int i = 0; i < n; i++) begin
            exp_cmd.push_back({rd ? 3'b001 : 3'b000, addr + 28'(i * 8)});
            cmd_pushed++;
            if (!rd) begin
                exp_dat.push_back(wr_data);
                dat_pushed++;
            end
        end
        d.rd      = rd;
        d.cmd_tot = cmd_pushed;
        d.dat_tot = dat_pushed;
        exp_done.push_back(d);
    endtask

    task automatic issue(input bit rd, input logic [27:0] addr, input int len);
        push_burst(rd, addr, len);
        if (rd) begin
            rd_addr = addr; rd_len = 5'(len); rd_req = 1'b1;
        end else begin
            wr_addr = addr; wr_len = 5'(len); wr_req = 1'b1;
        end
    endtask

    task automatic wait_grant(input string tag);
        int c = 0;
        while ((wr_req || rd_req) && c < 40) begin
            @(negedge aclk);
            c++;
            if (wr_grant) wr_req = 1'b0;
            if (rd_grant) rd_req = 1'b0;
        end
        chk({tag, "_grant_timeout"}, 192'(c < 40), 192'(1));
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        int c = 0;
        while ((wr_req || rd_req || exp_done.size() != 0) && c < budget) begin
            @(posedge aclk);
            #1;
            if (toggle_rdy) app_rdy = ~app_rdy;
            @(negedge aclk);
            c++;
            if (wr_grant) wr_req = 1'b0;
            if (rd_grant) rd_req = 1'b0;
        end
        chk({tag, "_timeout"}, 192'(c < budget), 192'(1));
    endtask

    // Scoreboard: compares every grant, command, data beat and done against the expected queues.
    always @(negedge aclk) begin
        if (!reset) begin
            if (wr_grant || rd_grant) begin
                chk("grant_expected", 192'(exp_gnt.size() != 0), 192'(1));
                if (exp_gnt.size() != 0) begin
                    mon_g = exp_gnt.pop_front();
                    chk("grant_order", 192'({rd_grant, wr_grant}), 192'(mon_g));
                end
            end
            if (app_en) begin
                chk("cmd_expected", 192'(exp_cmd.size() != 0), 192'(1));
                if (exp_cmd.size() != 0) begin
                    chk("cmd_addr", 192'({app_cmd, app_addr}), 192'(exp_cmd[0]));
                    if (app_rdy) begin
                        void'(exp_cmd.pop_front());
                        cmd_seen++;
                    end
                end
            end
            if (app_wdf_wren) begin
                chk("wdf_expected", 192'(exp_dat.size() != 0), 192'(1));
                chk("wr_data_ready", 192'(wr_data_ready), 192'(app_wdf_rdy));
                if (exp_dat.size() != 0) begin
                    chk("wdf_beat", 192'({app_wdf_end, app_wdf_mask, app_wdf_data}),
                        192'({1'b1, 16'h0, exp_dat[0]}));
                    if (app_wdf_rdy) begin
                        void'(exp_dat.pop_front());
                        dat_seen++;
                    end
                end
            end
            if (wr_done || rd_done) begin
                chk("done_expected", 192'(exp_done.size() != 0), 192'(1));
                if (exp_done.size() != 0) begin
                    mon_d = exp_done.pop_front();
                    chk("done_port", 192'({rd_done, wr_done}), 192'({mon_d.rd, ~mon_d.rd}));
                    chk("done_after_beats", 192'({cmd_seen, dat_seen}), 192'({mon_d.cmd_tot, mon_d.dat_tot}));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; init_calib = 1'b0;
        wr_req = 1'b0; wr_addr = '0; wr_len = '0; wr_data = '0; wr_data_valid = 1'b1;
        rd_req = 1'b0; rd_addr = '0; rd_len = '0;
        app_rdy = 1'b1; app_wdf_rdy = 1'b1;

        // Reset state.
        repeat (3) @(negedge aclk);
        chk("reset_outputs", outs(), '0);
        @(posedge aclk); #1;
        reset = 1'b0; init_calib = 1'b1;

        // Simultaneous requests, twice: write first after reset, then alternate.
        for (int r = 0; r < 2; r++) begin
            @(posedge aclk); #1;
            wr_data = 128'hA5A5_0000 + 128'(r);
            issue(1'b0, 28'h1000 + 28'(r * 'h100), 2);
            issue(1'b1, 28'h8000 + 28'(r * 'h100), 2);
            run_until_idle("rr", 100);
        end

        // Plain write burst, len 4 from 0x100.
        @(posedge aclk); #1;
        mark_cmd = cmd_seen; mark_dat = dat_seen;
        wr_data = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0;
        issue(1'b0, 28'h100, 4);
        run_until_idle("wr4", 100);
        chk("wr4_cmds", 192'(cmd_seen - mark_cmd), 192'(4));
        chk("wr4_beats", 192'(dat_seen - mark_dat), 192'(4));

        // Write was served last: with both pending, read must win.
        @(posedge aclk); #1;
        wr_data = 128'h5555_AAAA;
        issue(1'b1, 28'h9000, 2);
        issue(1'b0, 28'h3000, 2);
        run_until_idle("rr_rd_first", 100);

        // app_rdy toggling during a 3-beat read.
        @(posedge aclk); #1;
        mark_cmd = cmd_seen;
        toggle_rdy = 1'b1;
        issue(1'b1, 28'h500, 3);
        run_until_idle("toggle", 100);
        toggle_rdy = 1'b0; app_rdy = 1'b1;
        chk("toggle_cmds", 192'(cmd_seen - mark_cmd), 192'(3));

        // Data leads commands; calibration drop mid-burst must not abort.
        @(posedge aclk); #1;
        app_rdy = 1'b0;
        mark_cmd = cmd_seen; mark_dat = dat_seen;
        wr_data = 128'h1234_5678;
        issue(1'b0, 28'h2000, 2);
        wait_grant("lead");
        init_calib = 1'b0;
        repeat (10) @(negedge aclk);
        chk("lead_data_first", 192'(dat_seen - mark_dat), 192'(2));
        chk("lead_no_cmd_yet", 192'(cmd_seen - mark_cmd), 192'(0));
        chk("lead_no_done_yet", 192'(exp_done.size()), 192'(1));
        @(posedge aclk); #1;
        app_rdy = 1'b1;
        run_until_idle("lead", 50);
        chk("lead_cmds", 192'(cmd_seen - mark_cmd), 192'(2));

        // No grant while uncalibrated; address wraps at the top of the space.
        @(posedge aclk); #1;
        wr_data = 128'hCAFE;
        issue(1'b0, 28'hFFFFFF8, 2);
        for (int i = 0; i < 8; i++) begin
            @(negedge aclk);
            chk("calib_no_grant", 192'({rd_grant, wr_grant}), '0);
        end
        @(posedge aclk); #1;
        init_calib = 1'b1;
        run_until_idle("wrap", 50);

        // Zero-length read and an oversized read clamped to 16.
        @(posedge aclk); #1;
        mark_cmd = cmd_seen;
        issue(1'b1, 28'h700, 0);
        run_until_idle("len0", 50);
        chk("len0_cmds", 192'(cmd_seen - mark_cmd), 192'(0));
        @(posedge aclk); #1;
        issue(1'b1, 28'h800, 20);
        run_until_idle("clamp", 100);
        chk("clamp_cmds", 192'(cmd_seen - mark_cmd), 192'(16));

        // Reset asserted mid-burst.
        @(posedge aclk); #1;
        app_rdy = 1'b0;
        wr_data = 128'hBAD0;
        issue(1'b0, 28'h300, 4);
        wait_grant("rst");
        repeat (2) @(negedge aclk);
        chk("pre_reset_app_en", 192'(app_en), 192'(1));
        #2 reset = 1'b1;
        #1 chk("reset_async_outputs", outs(), '0);
        exp_cmd.delete(); exp_dat.delete(); exp_done.delete(); exp_gnt.delete();
        cmd_pushed = cmd_seen; dat_pushed = dat_seen;
        @(posedge aclk); #1;
        reset = 1'b0; app_rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge aclk);
            chk("rst_no_done", 192'({rd_done, wr_done}), '0);
        end
        @(posedge aclk); #1;
        wr_data = 128'h600D;
        issue(1'b0, 28'h400, 3);
        run_until_idle("post_reset", 100);

        chk("queues_empty", 192'(exp_cmd.size() + exp_dat.size() + exp_done.size() + exp_gnt.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
